// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the
// baud divisor helper used by both the receiver and the transmitter.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_t;

    // sys_clk cycles per serial bit
    function automatic int bps_cnt(input int clk_freq, input int bps);
        return clk_freq / bps;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line, plus one delay
// flop so a high-to-low transition can be flagged as a single-cycle fall.
module uart_rx_sync (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic uart_rxd,
    output logic rxd_s,
    output logic fall
);

    logic r_sync1;
    logic r_rxd_s;
    logic r_rxd_d;

    // Flops reset to the idle-line level so reset release never looks like a start bit
    // from a line that was idle high.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync1 <= 1'b1;
            r_rxd_s <= 1'b1;
            r_rxd_d <= 1'b1;
        end else begin
            r_sync1 <= uart_rxd;
            r_rxd_s <= r_sync1;
            r_rxd_d <= r_rxd_s;
        end
    end

    assign rxd_s = r_rxd_s;
    assign fall  = r_rxd_d & ~r_rxd_s;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: validates the start bit, samples each bit at mid-period,
// checks the stop bit and reports a good byte or a framing error as a pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 9600
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 uart_rxd,
    output logic                 rx_flag,
    output logic                 uart_done,
    output logic [DATA_BITS-1:0] uart_data,
    output logic                 frame_err
);

    localparam int          BPS_CNT    = bps_cnt(CLK_FREQ, UART_BPS);
    localparam logic [15:0] CNT_MAX    = 16'(BPS_CNT - 1);
    localparam logic [15:0] CNT_SAMPLE = 16'(BPS_CNT / 2);
    localparam logic [3:0]  LAST_BIT   = 4'(DATA_BITS - 1);

    logic w_rxd_s;
    logic w_fall;

    uart_rx_sync u_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .uart_rxd  (uart_rxd),
        .rxd_s     (w_rxd_s),
        .fall      (w_fall)
    );

    uart_state_t          r_state,   w_state_nxt;
    logic [15:0]          r_clk_cnt, w_clk_cnt_nxt;
    logic [3:0]           r_bit_cnt, w_bit_cnt_nxt;
    logic [DATA_BITS-1:0] r_shift,   w_shift_nxt;
    logic [DATA_BITS-1:0] r_data,    w_data_nxt;
    logic                 r_done,    w_done_nxt;
    logic                 r_err,     w_err_nxt;
    logic                 w_wrap;
    logic                 w_sample;

    assign w_wrap   = (r_clk_cnt == CNT_MAX);
    assign w_sample = (r_clk_cnt == CNT_SAMPLE);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_clk_cnt_nxt = w_wrap ? 16'd0 : r_clk_cnt + 16'd1;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_data_nxt    = r_data;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_clk_cnt_nxt = 16'd0;
                w_bit_cnt_nxt = 4'd0;
                if (w_fall) w_state_nxt = START;
            end
            START: begin
                if (w_sample && w_rxd_s) begin
                    // line already back high at mid start bit: glitch, not a frame
                    w_state_nxt   = IDLE;
                    w_clk_cnt_nxt = 16'd0;
                end else if (w_wrap) begin
                    w_state_nxt   = DATA;
                    w_bit_cnt_nxt = 4'd0;
                end
            end
            DATA: begin
                if (w_sample) w_shift_nxt[r_bit_cnt[2:0]] = w_rxd_s;
                if (w_wrap) begin
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_nxt   = STOP;
                        w_bit_cnt_nxt = 4'd0;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end
                end
            end
            STOP: begin
                // Leave at mid stop bit so a start bit right after the stop bit is caught.
                if (w_sample) begin
                    w_clk_cnt_nxt = 16'd0;
                    if (w_rxd_s) begin
                        w_data_nxt  = r_shift;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                w_clk_cnt_nxt = 16'd0;
                if (w_rxd_s) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt   = IDLE;
                w_clk_cnt_nxt = 16'd0;
            end
        endcase
    end

    // NOTE: the shift register is reset along with the control state; it is a few flops, not a memory.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= IDLE;
            r_clk_cnt <= 16'd0;
            r_bit_cnt <= 4'd0;
            r_shift   <= '0;
            r_data    <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clk_cnt <= w_clk_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_data    <= w_data_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign rx_flag   = (r_state != IDLE);
    assign uart_done = r_done;
    assign uart_data = r_data;
    assign frame_err = r_err;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are built from bytes, and
// expected bytes and pulse counts come from a queue-based frame model.
module tb_uart_rx;

    localparam int CLK_FREQ = 1000000;
    localparam int UART_BPS = 100000;
    localparam int BPS      = CLK_FREQ / UART_BPS;
    // start-bit drive to uart_done: 2 sync cycles + fall-to-done latency
    localparam int LATENCY  = 9 * BPS + BPS / 2 + 2 + 2;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       uart_rxd  = 1'b1;
    logic       rx_flag;
    logic       uart_done;
    logic [7:0] uart_data;
    logic       frame_err;

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .uart_rxd  (uart_rxd),
        .rx_flag   (rx_flag),
        .uart_done (uart_done),
        .uart_data (uart_data),
        .frame_err (frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc      = 0;
    int         n_done   = 0;
    int         n_ferr   = 0;
    logic [7:0] exp_q[$];
    int         done_cycs[$];
    logic [7:0] exp_last = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Scoreboard: every done pulse must match the oldest good frame sent.
    always @(negedge sys_clk) begin
        if (uart_done | frame_err)
            check("done_err_exclusive", {31'd0, uart_done & frame_err}, 32'd0);
        if (uart_done) begin
            n_done++;
            done_cycs.push_back(cyc);
            if (exp_q.size() > 0) check("done_data", {24'd0, uart_data}, {24'd0, exp_q.pop_front()});
            else                  check("done_unexpected", {31'd0, uart_done}, 32'd0);
        end
        if (frame_err) n_ferr++;
    end

    task automatic idle(input int n);
        uart_rxd = 1'b1;
        repeat (n) @(negedge sys_clk);
    endtask

    // One 8N1 frame; p10 is the bit period in tenths of a cycle.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int p10);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        if (stop) begin
            exp_q.push_back(b);
            exp_last = b;
        end
        for (int k = 0; k < 10; k++) begin
            uart_rxd = bits[k];
            repeat (((k + 1) * p10) / 10 - (k * p10) / 10) @(negedge sys_clk);
        end
        uart_rxd = 1'b1;
    endtask

    task automatic check_quiet(input string tag, input int done0, input int ferr0);
        check({tag, "_done_cnt"}, n_done, done0);
        check({tag, "_ferr_cnt"}, n_ferr, ferr0);
        check({tag, "_data_held"}, {24'd0, uart_data}, {24'd0, exp_last});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         t0, d0, f0;
        logic [7:0] b;
        logic [9:0] bits;

        // reset values
        repeat (3) @(negedge sys_clk);
        check("rst_rx_flag", {31'd0, rx_flag}, 0);
        check("rst_done", {31'd0, uart_done}, 0);
        check("rst_data", {24'd0, uart_data}, 0);
        check("rst_ferr", {31'd0, frame_err}, 0);
        sys_rst_n = 1'b1;
        idle(5);

        // single byte, with latency
        done_cycs.delete();
        t0 = cyc;
        send_frame(8'hA5, 1'b1, 100);
        idle(10);
        check("a5_done_cnt", n_done, 1);
        if (done_cycs.size() > 0) check("a5_latency", done_cycs[0] - t0, LATENCY);
        else                      check("a5_latency_missing", done_cycs.size(), 1);
        check("a5_data", {24'd0, uart_data}, 32'hA5);
        check("a5_rx_flag_low", {31'd0, rx_flag}, 0);
        check("a5_ferr_cnt", n_ferr, 0);

        // back-to-back frames, one stop bit each
        done_cycs.delete();
        send_frame(8'h00, 1'b1, 100);
        send_frame(8'hFF, 1'b1, 100);
        send_frame(8'h3C, 1'b1, 100);
        idle(10);
        check("b2b_done_cnt", n_done, 4);
        if (done_cycs.size() == 3) begin
            check("b2b_gap1", done_cycs[1] - done_cycs[0], 10 * BPS);
            check("b2b_gap2", done_cycs[2] - done_cycs[1], 10 * BPS);
        end else begin
            check("b2b_pulses", done_cycs.size(), 3);
        end

        // random bytes with random idle gaps
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, 100);
            idle($urandom_range(0, 20));
        end
        idle(10);
        check("rand_done_cnt", n_done, 12);
        check("rand_data", {24'd0, uart_data}, {24'd0, exp_last});

        // 3-cycle low glitch on the idle line
        d0 = n_done; f0 = n_ferr;
        uart_rxd = 1'b0;
        repeat (3) @(negedge sys_clk);
        idle(2);
        check("glitch_rx_flag_high", {31'd0, rx_flag}, 1);
        idle(10);
        check("glitch_rx_flag_low", {31'd0, rx_flag}, 0);
        check_quiet("glitch", d0, f0);

        // stop bit low, then line held low: one frame error, then recovery
        d0 = n_done; f0 = n_ferr;
        send_frame(8'h5A, 1'b0, 100);
        uart_rxd = 1'b0;
        repeat (150) @(negedge sys_clk);
        check("break_rx_flag", {31'd0, rx_flag}, 1);
        repeat (140) @(negedge sys_clk);
        idle(20);
        check("break_rx_flag_low", {31'd0, rx_flag}, 0);
        check_quiet("break", d0, f0 + 1);
        send_frame(8'h81, 1'b1, 100);
        idle(10);
        check("after_break_done_cnt", n_done, d0 + 1);
        check("after_break_data", {24'd0, uart_data}, 32'h81);

        // reset during data bit 4; bits 4..7 high so the tail has no falling edge
        d0 = n_done;
        b = {4'hF, 4'($urandom)};
        bits = {1'b1, b, 1'b0};
        for (int k = 0; k < 5; k++) begin
            uart_rxd = bits[k];
            repeat (BPS) @(negedge sys_clk);
        end
        uart_rxd = bits[5];
        repeat (5) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check("midrst_rx_flag", {31'd0, rx_flag}, 0);
        check("midrst_done", {31'd0, uart_done}, 0);
        check("midrst_data", {24'd0, uart_data}, 0);
        check("midrst_ferr", {31'd0, frame_err}, 0);
        exp_last = 8'h00;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        for (int k = 6; k < 10; k++) begin
            uart_rxd = bits[k];
            repeat (BPS) @(negedge sys_clk);
        end
        idle(30);
        check("midrst_no_done", n_done, d0);
        send_frame(8'h42, 1'b1, 100);
        idle(10);
        check("midrst_next_done_cnt", n_done, d0 + 1);
        check("midrst_next_data", {24'd0, uart_data}, 32'h42);

        // baud tolerance: +4% and -4% bit periods
        d0 = n_done;
        send_frame(8'hC3, 1'b1, 104);
        idle(20);
        check("slow_data", {24'd0, uart_data}, 32'hC3);
        send_frame(8'hC3, 1'b1, 96);
        idle(20);
        check("fast_data", {24'd0, uart_data}, 32'hC3);
        check("tol_done_cnt", n_done, d0 + 2);
        check("tol_ferr_cnt", n_ferr, f0 + 1);

        check("exp_q_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
